// File: rtl/id_hazard_ctrl.sv
// Hazard controller beside the ID stage: shadows the destination state of the
// EX/MEM/WB instructions and derives stall, bubble, flush, operand-forward and
// flag-forward controls, plus a saturating stall-cycle counter.
module id_hazard_ctrl #(
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_Rn,
    input  logic [4:0]       id_Ab,
    input  logic             id_use_rn,
    input  logic             id_use_ab,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic [4:0]       id_Rd,
    input  logic             id_update,
    input  logic             id_cbz,
    input  logic             id_bcond,
    input  logic             id_BrTaken,
    output logic             stall,
    output logic             bubble,
    output logic             flush_ifid,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             flag_fwd,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [4:0] ZR = 5'(ZERO_REG);

    // Full record for the instruction in EX; its sources drive forwarding.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       update;
        logic [4:0] rd;
        logic [4:0] rn;
        logic [4:0] ab;
        logic       use_rn;
        logic       use_ab;
    } ex_rec_t;

    // MEM and WB only ever act as producers, so they keep destination fields only.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] rd;
    } mem_rec_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [4:0] rd;
    } wb_rec_t;

    ex_rec_t  ex_r;
    ex_rec_t  id_rec;
    mem_rec_t mem_r;
    wb_rec_t  wb_r;

    logic load_use;
    logic cbz_hold;
    logic hold;

    // A producer writes register a when valid, writing, and a is not the zero register.
    function automatic logic writes(input logic valid, input logic reg_write,
                                    input logic [4:0] rd, input logic [4:0] a);
        return valid & reg_write & (rd == a) & (a != ZR);
    endfunction

    // Forward select for one EX operand; the newest producer (MEM) wins over WB.
    function automatic logic [1:0] fwd_sel(input logic ex_valid, input logic use_src,
                                           input logic [4:0] src,
                                           input mem_rec_t m, input wb_rec_t w);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_valid && use_src) begin
            if (writes(m.valid, m.reg_write, m.rd, src))
                sel = 2'b01;
            else if (writes(w.valid, w.reg_write, w.rd, src))
                sel = 2'b10;
        end
        return sel;
    endfunction

    // Pack the ID-stage fields into the record that enters EX.
    always_comb begin
        id_rec           = '0;
        id_rec.valid     = id_valid;
        id_rec.reg_write = id_RegWrite;
        id_rec.mem_read  = id_MemRead;
        id_rec.update    = id_update;
        id_rec.rd        = id_Rd;
        id_rec.rn        = id_Rn;
        id_rec.ab        = id_Ab;
        id_rec.use_rn    = id_use_rn;
        id_rec.use_ab    = id_use_ab;
    end

    // Hazard detection and all combinational pipeline controls; reset masks them.
    always_comb begin
        load_use = ex_r.mem_read &
                   ((id_use_rn & writes(ex_r.valid, ex_r.reg_write, ex_r.rd, id_Rn)) |
                    (id_use_ab & writes(ex_r.valid, ex_r.reg_write, ex_r.rd, id_Ab)));
        cbz_hold = id_cbz &
                   (writes(ex_r.valid, ex_r.reg_write, ex_r.rd, id_Ab) |
                    (mem_r.mem_read & writes(mem_r.valid, mem_r.reg_write, mem_r.rd, id_Ab)));
        hold       = ~reset & id_valid & (load_use | cbz_hold);
        stall      = hold;
        bubble     = hold;
        flush_ifid = ~reset & id_valid & id_BrTaken & ~hold;
        flag_fwd   = ~reset & id_valid & id_bcond & ex_r.valid & ex_r.update;
        fwd_a      = reset ? 2'b00 : fwd_sel(ex_r.valid, ex_r.use_rn, ex_r.rn, mem_r, wb_r);
        fwd_b      = reset ? 2'b00 : fwd_sel(ex_r.valid, ex_r.use_ab, ex_r.ab, mem_r, wb_r);
    end

    // Shadow pipeline: EX takes the ID instruction unless stalled, otherwise a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else begin
            wb_r.valid      <= mem_r.valid;
            wb_r.reg_write  <= mem_r.reg_write;
            wb_r.rd         <= mem_r.rd;
            mem_r.valid     <= ex_r.valid;
            mem_r.reg_write <= ex_r.reg_write;
            mem_r.mem_read  <= ex_r.mem_read;
            mem_r.rd        <= ex_r.rd;
            ex_r            <= (id_valid && !hold) ? id_rec : '0;
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (hold && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: instruction-level pipeline model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_id_hazard_ctrl;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          id_valid;
    logic [4:0]    id_Rn, id_Ab, id_Rd;
    logic          id_use_rn, id_use_ab, id_RegWrite, id_MemRead;
    logic          id_update, id_cbz, id_bcond, id_BrTaken;
    logic          stall, bubble, flush_ifid, flag_fwd;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt;

    id_hazard_ctrl #(.ZERO_REG(31), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_Rn(id_Rn), .id_Ab(id_Ab), .id_use_rn(id_use_rn), .id_use_ab(id_use_ab),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_Rd(id_Rd),
        .id_update(id_update), .id_cbz(id_cbz), .id_bcond(id_bcond),
        .id_BrTaken(id_BrTaken), .stall(stall), .bubble(bubble),
        .flush_ifid(flush_ifid), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .flag_fwd(flag_fwd), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [4:0] rn;
        logic [4:0] ab;
        logic       urn;
        logic       uab;
        logic       rw;
        logic       mr;
        logic [4:0] rd;
        logic       upd;
        logic       cbz;
        logic       bcond;
        logic       taken;
    } ins_t;

    int vectors    = 0;
    int miscompares = 0;

    // Model state: instructions in EX, MEM, WB (index 0,1,2), and stall count.
    ins_t pipe [3];
    int   m_cnt;
    bit   known = 0;

    // Last sampled DUT outputs and model decisions.
    int   l_stall, l_bubble, l_flush, l_flag, l_fa, l_fb, l_cnt;
    bit   e_stall;
    int   n_stall, d_stall;

    function automatic ins_t nop();
        ins_t i = '0;
        return i;
    endfunction

    function automatic ins_t ldur(input int rd, input int rn);
        ins_t i = '0;
        i.valid = 1; i.rn = 5'(rn); i.urn = 1; i.ab = 5'(rd);
        i.rw = 1; i.mr = 1; i.rd = 5'(rd);
        return i;
    endfunction

    function automatic ins_t alu(input int rd, input int rn, input int rm, input bit upd);
        ins_t i = '0;
        i.valid = 1; i.rn = 5'(rn); i.ab = 5'(rm); i.urn = 1; i.uab = 1;
        i.rw = 1; i.rd = 5'(rd); i.upd = upd;
        return i;
    endfunction

    function automatic ins_t cbz(input int rt, input bit taken);
        ins_t i = '0;
        i.valid = 1; i.ab = 5'(rt); i.uab = 1; i.cbz = 1; i.taken = taken;
        return i;
    endfunction

    function automatic ins_t bcond(input bit taken);
        ins_t i = '0;
        i.valid = 1; i.bcond = 1; i.taken = taken;
        return i;
    endfunction

    function automatic bit wr(input ins_t p, input logic [4:0] r);
        return p.valid && p.rw && (p.rd == r) && (r != 5'd31);
    endfunction

    function automatic int src_sel(input ins_t e, input ins_t m, input ins_t w,
                                   input logic [4:0] r, input bit used);
        if (!e.valid || !used) return 0;
        if (wr(m, r)) return 1;
        if (wr(w, r)) return 2;
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive ID, compare all outputs against the model, advance the model.
    task automatic cycle(input ins_t i, input bit rst);
        bit hz, e_flush, e_flag;
        int e_fa, e_fb;
        reset = rst; id_valid = i.valid; id_Rn = i.rn; id_Ab = i.ab;
        id_use_rn = i.urn; id_use_ab = i.uab; id_RegWrite = i.rw; id_MemRead = i.mr;
        id_Rd = i.rd; id_update = i.upd; id_cbz = i.cbz; id_bcond = i.bcond;
        id_BrTaken = i.taken;
        @(negedge clk);
        hz = (pipe[0].mr && ((i.urn && wr(pipe[0], i.rn)) || (i.uab && wr(pipe[0], i.ab))))
          || (i.cbz && (wr(pipe[0], i.ab) || (pipe[1].mr && wr(pipe[1], i.ab))));
        e_stall = !rst && i.valid && hz;
        e_flush = !rst && i.valid && i.taken && !e_stall;
        e_flag  = !rst && i.valid && i.bcond && pipe[0].valid && pipe[0].upd;
        e_fa    = rst ? 0 : src_sel(pipe[0], pipe[1], pipe[2], pipe[0].rn, pipe[0].urn);
        e_fb    = rst ? 0 : src_sel(pipe[0], pipe[1], pipe[2], pipe[0].ab, pipe[0].uab);
        l_stall = int'(stall); l_bubble = int'(bubble); l_flush = int'(flush_ifid);
        l_flag = int'(flag_fwd); l_fa = int'(fwd_a); l_fb = int'(fwd_b); l_cnt = int'(stall_cnt);
        if (known) begin
            check("stall",      l_stall,  int'(e_stall));
            check("bubble",     l_bubble, int'(e_stall));
            check("flush_ifid", l_flush,  int'(e_flush));
            check("flag_fwd",   l_flag,   int'(e_flag));
            check("fwd_a",      l_fa,     e_fa);
            check("fwd_b",      l_fb,     e_fb);
            check("stall_cnt",  l_cnt,    m_cnt);
        end
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = '0;
            m_cnt = 0;
            known = 1;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (i.valid && !e_stall) ? i : '0;
            if (e_stall && m_cnt < SAT) m_cnt++;
        end
        #1;
    endtask

    // Hold an instruction in ID until the model says it issues (bounded).
    task automatic run(input ins_t i);
        bit done = 0;
        n_stall = 0;
        d_stall = 0;
        for (int k = 0; k < 6 && !done; k++) begin
            cycle(i, 0);
            d_stall += l_stall;
            if (e_stall) n_stall++;
            else done = 1;
        end
        if (!done) check("issue_timeout", 0, 1);
    endtask

    initial begin
        ins_t junk;
        reset = 1; id_valid = 0; id_Rn = 0; id_Ab = 0; id_use_rn = 0; id_use_ab = 0;
        id_RegWrite = 0; id_MemRead = 0; id_Rd = 0; id_update = 0; id_cbz = 0;
        id_bcond = 0; id_BrTaken = 0;
        #1;

        // Reset with busy ID inputs: everything must read zero.
        junk = cbz(5, 1);
        junk.bcond = 1;
        cycle(junk, 1);
        cycle(junk, 1);
        check("rst_flush", l_flush, 0);
        check("rst_cnt", l_cnt, 0);

        // Load-use: one stall, then MEM/WB forward of the loaded value.
        run(ldur(2, 10));
        run(alu(3, 2, 4, 0));
        check("lu_stall_cycles", n_stall, 1);
        check("lu_dut_stalls", d_stall, 1);
        run(nop());
        check("lu_fwd_a", l_fa, 2);
        check("lu_cnt", l_cnt, 1);

        // ALU chain: EX/MEM forward on both operands, MEM/WB two cycles later.
        run(alu(1, 2, 3, 0));
        run(alu(5, 1, 1, 0));
        check("chain_stall", n_stall, 0);
        run(alu(6, 1, 8, 0));
        check("chain_fwd_a", l_fa, 1);
        check("chain_fwd_b", l_fb, 1);
        run(nop());
        check("chain3_fwd_a", l_fa, 2);
        check("chain3_fwd_b", l_fb, 0);

        // CBZ behind a load: two stalls, then a taken flush on the third cycle.
        run(ldur(7, 11));
        run(cbz(7, 1));
        check("cbz_stall_cycles", n_stall, 2);
        check("cbz_dut_stalls", d_stall, 2);
        check("cbz_flush", l_flush, 1);

        // CBZ behind an ALU producer in EX stalls once, then forwards from MEM.
        run(alu(4, 1, 2, 0));
        run(cbz(4, 0));
        check("cbz_alu_stalls", n_stall, 1);

        // Flags: ADDS then taken B.cond forwards flags and flushes at once.
        run(alu(9, 1, 2, 1));
        run(bcond(1));
        check("flag_stall", n_stall, 0);
        check("flag_fwd_lit", l_flag, 1);
        check("flag_flush", l_flush, 1);

        // XZR as load destination and as sources never hazards.
        run(ldur(31, 12));
        run(alu(1, 31, 31, 0));
        check("xzr_stall", n_stall, 0);
        run(nop());
        check("xzr_fwd_a", l_fa, 0);
        check("xzr_fwd_b", l_fb, 0);

        // Invalid ID slot with hazard-looking fields asserts nothing.
        run(ldur(2, 10));
        junk = alu(3, 2, 2, 0);
        junk.valid = 0;
        junk.taken = 1;
        run(junk);
        check("inv_stall", l_stall, 0);
        check("inv_flush", l_flush, 0);

        // Reset in the middle of a CBZ stall.
        run(ldur(7, 11));
        cycle(cbz(7, 0), 0);
        check("rcbz_stall", l_stall, 1);
        cycle(cbz(7, 0), 1);
        cycle(cbz(7, 0), 0);
        check("rcbz_after_stall", l_stall, 0);
        check("rcbz_after_cnt", l_cnt, 0);
        check("rcbz_after_fwd", l_fa + l_fb, 0);

        // Saturation: 20 load-use stalls on a 4-bit counter holds at 15.
        for (int r = 0; r < 20; r++) begin
            run(ldur(2, 10));
            run(alu(3, 2, 4, 0));
        end
        run(nop());
        check("sat_cnt", l_cnt, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
